// File: rtl/screen_sequencer.sv
// Game-flow controller: picks the active screen drawer's tile map, sprites and seconds for the renderer.
// Latency: all outputs registered, one cycle after state/inputs; jump path adds 2-flop sync + edge detect.
// Backpressure: none; free-running, jump edges arriving before the end-screen hold expires are dropped.
module screen_sequencer #(
    parameter int CLOCK_HZ         = 25_000_000,
    parameter int END_HOLD_SECONDS = 3,
    parameter int HIDDEN_POS       = 1000
) (
    input  logic                    vga_clock,
    input  logic                    reset,
    input  logic                    jump_button,
    input  logic [11:0][16:0][7:0]  title_background,
    input  logic [11:0][16:0][7:0]  level_background,
    input  logic [11:0][16:0][7:0]  win_background,
    input  logic [11:0][16:0][7:0]  over_background,
    input  int                      level_mario_x,
    input  int                      level_mario_y,
    input  int                      level_goomba_x,
    input  int                      level_goomba_y,
    input  int                      level_seconds,
    input  logic                    level_win,
    input  logic                    level_lose,
    output logic [11:0][16:0][7:0]  background,
    output int                      mario_x,
    output int                      mario_y,
    output int                      goomba_x,
    output int                      goomba_y,
    output int                      seconds,
    output logic                    level_reset,
    output logic [1:0]              screen_state,
    output logic [9:0]              leds
);

    localparam int HOLD = END_HOLD_SECONDS * CLOCK_HZ;
    localparam int CW   = $clog2(HOLD + 1);

    typedef enum logic [1:0] {TITLE = 2'd0, PLAYING = 2'd1, WIN = 2'd2, GAME_OVER = 2'd3} state_t;

    state_t                 state, state_nxt;
    logic                   jump_s1, jump_s2, jump_prev;
    logic                   jump_edge;
    logic [CW-1:0]          hold_cnt;
    logic                   hold_done;
    int                     frozen_seconds;
    logic                   end_nxt;

    logic [11:0][16:0][7:0] background_d;
    int                     mario_x_d, mario_y_d, goomba_x_d, goomba_y_d, seconds_d;
    logic [9:0]             leds_d;

    assign jump_edge = jump_s2 & ~jump_prev;
    assign hold_done = (hold_cnt == CW'(HOLD));
    assign end_nxt   = (state_nxt == WIN) || (state_nxt == GAME_OVER);

    // State, jump synchroniser and end-screen hold counter.
    always_ff @(posedge vga_clock) begin
        if (reset) begin
            state          <= TITLE;
            jump_s1        <= 1'b0;
            jump_s2        <= 1'b0;
            jump_prev      <= 1'b0;
            hold_cnt       <= '0;
            frozen_seconds <= 0;
        end else begin
            state     <= state_nxt;
            jump_s1   <= jump_button;
            jump_s2   <= jump_s1;
            jump_prev <= jump_s2;
            if (end_nxt && (state_nxt != state)) begin
                hold_cnt       <= '0;
                frozen_seconds <= level_seconds;
            end else if (end_nxt) begin
                if (!hold_done)
                    hold_cnt <= hold_cnt + CW'(1);
            end else begin
                hold_cnt <= '0;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            TITLE:     if (jump_edge) state_nxt = PLAYING;
            PLAYING:   begin
                if (level_win)       state_nxt = WIN;
                else if (level_lose) state_nxt = GAME_OVER;
            end
            WIN,
            GAME_OVER: if (jump_edge && hold_done) state_nxt = TITLE;
            default:   state_nxt = TITLE;
        endcase
    end

    always_comb begin
        background_d = title_background;
        mario_x_d    = HIDDEN_POS;
        mario_y_d    = HIDDEN_POS;
        goomba_x_d   = HIDDEN_POS;
        goomba_y_d   = HIDDEN_POS;
        seconds_d    = 0;
        leds_d       = {5'b0, hold_done, 4'(4'b0001 << state)};
        case (state)
            PLAYING: begin
                background_d = level_background;
                mario_x_d    = level_mario_x;
                mario_y_d    = level_mario_y;
                goomba_x_d   = level_goomba_x;
                goomba_y_d   = level_goomba_y;
                seconds_d    = level_seconds;
            end
            WIN: begin
                background_d = win_background;
                seconds_d    = frozen_seconds;
            end
            GAME_OVER: begin
                background_d = over_background;
                seconds_d    = frozen_seconds;
            end
            default: ;
        endcase
    end

    // level_reset follows next-state so the drawer leaves reset on the same edge PLAYING begins.
    always_ff @(posedge vga_clock) begin
        if (reset) begin
            background   <= title_background;
            mario_x      <= HIDDEN_POS;
            mario_y      <= HIDDEN_POS;
            goomba_x     <= HIDDEN_POS;
            goomba_y     <= HIDDEN_POS;
            seconds      <= 0;
            level_reset  <= 1'b1;
            screen_state <= 2'd0;
            leds         <= 10'b00_0000_0001;
        end else begin
            background   <= background_d;
            mario_x      <= mario_x_d;
            mario_y      <= mario_y_d;
            goomba_x     <= goomba_x_d;
            goomba_y     <= goomba_y_d;
            seconds      <= seconds_d;
            level_reset  <= (state_nxt != PLAYING);
            screen_state <= state;
            leds         <= leds_d;
        end
    end

endmodule

// File: tb/tb_screen_sequencer.sv
// Bench for screen_sequencer: directed walk through the game flow, then random play,
// every cycle compared against a behavioural model of the screen rules.
module tb_screen_sequencer;

    localparam int CLOCK_HZ = 10;
    localparam int END_HOLD = 2;
    localparam int HOLD     = CLOCK_HZ * END_HOLD;
    localparam int HIDDEN   = 1000;

    logic                   vga_clock;
    logic                   reset;
    logic                   jump_button;
    logic [11:0][16:0][7:0] title_background, level_background, win_background, over_background;
    int                     level_mario_x, level_mario_y, level_goomba_x, level_goomba_y, level_seconds;
    logic                   level_win, level_lose;
    logic [11:0][16:0][7:0] background;
    int                     mario_x, mario_y, goomba_x, goomba_y, seconds;
    logic                   level_reset;
    logic [1:0]             screen_state;
    logic [9:0]             leds;

    screen_sequencer #(.CLOCK_HZ(CLOCK_HZ), .END_HOLD_SECONDS(END_HOLD), .HIDDEN_POS(HIDDEN)) dut (
        .vga_clock(vga_clock), .reset(reset), .jump_button(jump_button),
        .title_background(title_background), .level_background(level_background),
        .win_background(win_background), .over_background(over_background),
        .level_mario_x(level_mario_x), .level_mario_y(level_mario_y),
        .level_goomba_x(level_goomba_x), .level_goomba_y(level_goomba_y),
        .level_seconds(level_seconds), .level_win(level_win), .level_lose(level_lose),
        .background(background), .mario_x(mario_x), .mario_y(mario_y),
        .goomba_x(goomba_x), .goomba_y(goomba_y), .seconds(seconds),
        .level_reset(level_reset), .screen_state(screen_state), .leds(leds)
    );

    initial vga_clock = 1'b0;
    always #5 vga_clock = ~vga_clock;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0d, expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Behavioural model: screen index, cycles spent on an end screen, and button samples seen so far.
    int                     m_screen, m_stay, m_frozen;
    logic                   btn_hist [$];
    logic [11:0][16:0][7:0] e_bg;
    int                     e_mx, e_my, e_gx, e_gy, e_sec, e_state;
    logic                   e_lr;
    logic [9:0]             e_leds;

    always @(posedge vga_clock) begin
        int  nxt;
        logic pressed;
        if (reset) begin
            m_screen = 0; m_stay = 0; m_frozen = 0;
            btn_hist.delete();
            repeat (3) btn_hist.push_back(1'b0);
            e_bg = title_background;
            e_mx = HIDDEN; e_my = HIDDEN; e_gx = HIDDEN; e_gy = HIDDEN;
            e_sec = 0; e_lr = 1'b1; e_state = 0; e_leds = 10'd1;
        end else begin
            // A press is seen two samples late (synchroniser) as a 0->1 step in the button history.
            pressed = btn_hist[btn_hist.size()-2] && !btn_hist[btn_hist.size()-3];
            e_state = m_screen;
            e_leds  = 10'(1 << m_screen) | ((m_stay >= HOLD) ? 10'h010 : 10'h000);
            e_mx = HIDDEN; e_my = HIDDEN; e_gx = HIDDEN; e_gy = HIDDEN;
            case (m_screen)
                0: begin e_bg = title_background; e_sec = 0; end
                1: begin
                    e_bg = level_background; e_sec = level_seconds;
                    e_mx = level_mario_x; e_my = level_mario_y;
                    e_gx = level_goomba_x; e_gy = level_goomba_y;
                end
                2: begin e_bg = win_background;  e_sec = m_frozen; end
                default: begin e_bg = over_background; e_sec = m_frozen; end
            endcase
            nxt = m_screen;
            if (m_screen == 0 && pressed) nxt = 1;
            else if (m_screen == 1 && level_win) nxt = 2;
            else if (m_screen == 1 && level_lose) nxt = 3;
            else if (m_screen >= 2 && pressed && m_stay >= HOLD) nxt = 0;
            e_lr = (nxt != 1);
            if (nxt >= 2 && nxt != m_screen) begin m_stay = 0; m_frozen = level_seconds; end
            else if (nxt >= 2) m_stay = (m_stay < HOLD) ? m_stay + 1 : HOLD;
            else m_stay = 0;
            m_screen = nxt;
            btn_hist.push_back(jump_button);
            if (btn_hist.size() > 3) void'(btn_hist.pop_front());
        end
    end

    logic chk_en = 1'b0;
    always @(negedge vga_clock) begin
        if (chk_en) begin
            chk("screen_state", 64'(screen_state), 64'(e_state));
            chk("level_reset", 64'(level_reset), 64'(e_lr));
            chk("leds", 64'(leds), 64'(e_leds));
            chk("background", 64'(background == e_bg), 64'd1);
            chk("mario_x", 64'(mario_x), 64'(e_mx));
            chk("mario_y", 64'(mario_y), 64'(e_my));
            chk("goomba_x", 64'(goomba_x), 64'(e_gx));
            chk("goomba_y", 64'(goomba_y), 64'(e_gy));
            chk("seconds", 64'(seconds), 64'(e_sec));
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge vga_clock);
    endtask

    task automatic pulse_jump();
        jump_button = 1'b1;
        cyc(1);
        jump_button = 1'b0;
    endtask

    initial begin
        reset = 1'b1; jump_button = 1'b0; level_win = 1'b0; level_lose = 1'b0;
        level_mario_x = 0; level_mario_y = 0; level_goomba_x = 0; level_goomba_y = 0; level_seconds = 0;
        for (int r = 0; r < 12; r++)
            for (int c = 0; c < 17; c++) begin
                title_background[r][c] = 8'($urandom);
                level_background[r][c] = 8'($urandom);
                win_background[r][c]   = 8'($urandom);
                over_background[r][c]  = 8'($urandom);
            end
        cyc(2);
        chk_en = 1'b1;
        reset  = 1'b0;
        cyc(5);
        chk("idle_state", 64'(screen_state), 64'd0);
        chk("idle_lr", 64'(level_reset), 64'd1);
        chk("idle_mx", 64'(mario_x), 64'd1000);
        chk("idle_leds", 64'(leds), 64'h001);
        chk("idle_bg", 64'(background == title_background), 64'd1);

        level_mario_x = 123;
        jump_button = 1'b1; cyc(4); jump_button = 1'b0; cyc(4);
        chk("play_state", 64'(screen_state), 64'd1);
        chk("play_lr", 64'(level_reset), 64'd0);
        chk("play_mx", 64'(mario_x), 64'd123);

        level_seconds = 42; level_win = 1'b1; level_lose = 1'b1; cyc(1);
        level_win = 1'b0; level_lose = 1'b0; level_seconds = 50; cyc(3);
        chk("win_state", 64'(screen_state), 64'd2);
        chk("win_frozen", 64'(seconds), 64'd42);
        chk("win_lr", 64'(level_reset), 64'd1);
        level_lose = 1'b1; cyc(2); level_lose = 1'b0; cyc(1);
        chk("win_ignores_lose", 64'(screen_state), 64'd2);

        cyc(25); pulse_jump(); cyc(5);
        chk("win_exit", 64'(screen_state), 64'd0);
        level_lose = 1'b1; cyc(2); level_lose = 1'b0; cyc(2);
        chk("title_ignores_lose", 64'(screen_state), 64'd0);

        pulse_jump(); cyc(5);
        level_seconds = 7; level_lose = 1'b1; cyc(1); level_lose = 1'b0; cyc(4);
        pulse_jump(); cyc(5);
        chk("over_early_jump", 64'(screen_state), 64'd3);
        cyc(20);
        chk("over_saturated", 64'(leds[4]), 64'd1);
        pulse_jump(); cyc(5);
        chk("over_exit", 64'(screen_state), 64'd0);

        pulse_jump(); cyc(6);
        level_seconds = 33;
        reset = 1'b1; cyc(1); reset = 1'b0;
        chk("rst_state", 64'(screen_state), 64'd0);
        chk("rst_lr", 64'(level_reset), 64'd1);
        chk("rst_sec", 64'(seconds), 64'd0);
        chk("rst_mx", 64'(mario_x), 64'd1000);

        for (int i = 0; i < 3000; i++) begin
            reset          = ($urandom_range(0, 599) == 0);
            if ($urandom_range(0, 7) == 0) jump_button = ~jump_button;
            level_win      = ($urandom_range(0, 39) == 0);
            level_lose     = ($urandom_range(0, 39) == 0);
            level_seconds  = int'($urandom_range(0, 999));
            level_mario_x  = int'($urandom_range(0, 639));
            level_mario_y  = int'($urandom_range(0, 479));
            level_goomba_x = int'($urandom_range(0, 639));
            level_goomba_y = int'($urandom_range(0, 479));
            cyc(1);
        end
        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
